uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state type.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;
    localparam int unsigned CLK_FREQ_HZ    = 100_000_000;
    localparam int unsigned BAUD_RATE      = 9600;
    // Clocks per br_tick for the shared baud-rate generator.
    localparam int unsigned BAUD_TICK_DIV  = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE_DEF);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to 1 so an idle serial line reads as idle.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, one stop bit.
// Define UART_RX_FRAME_ERR_EN to flag a low stop bit on frame_err instead of ignoring it.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_e            r_state, w_state_d;
    logic [TW-1:0]        r_tick, w_tick_d;
    logic [BW-1:0]        r_bit, w_bit_d;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic [DATA_BITS-1:0] r_data, w_data_d;
    logic                 r_done, w_done_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic                 r_err, w_err_d;
`endif

    sync_2ff u_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_tick  <= w_tick_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            r_data  <= w_data_d;
            r_done  <= w_done_d;
`ifdef UART_RX_FRAME_ERR_EN
            r_err   <= w_err_d;
`endif
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_tick_d  = r_tick;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_data_d  = r_data;
        w_done_d  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        w_err_d   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (!w_rx_s) begin
                    w_tick_d  = '0;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (br_tick) begin
                    if (r_tick == TICK_MID) begin
                        // Mid-start-bit check rejects glitches shorter than half a bit.
                        if (!w_rx_s) begin
                            w_tick_d  = '0;
                            w_bit_d   = '0;
                            w_state_d = StData;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        w_tick_d = r_tick + 1'b1;
                    end
                end
            end
            StData: begin
                if (br_tick) begin
                    if (r_tick == TICK_END) begin
                        w_tick_d  = '0;
                        w_shift_d = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit == BIT_LAST) begin
                            w_state_d = StStop;
                        end else begin
                            w_bit_d = r_bit + 1'b1;
                        end
                    end else begin
                        w_tick_d = r_tick + 1'b1;
                    end
                end
            end
            StStop: begin
                if (br_tick) begin
                    if (r_tick == TICK_END) begin
                        w_tick_d  = '0;
                        w_state_d = StIdle;
`ifdef UART_RX_FRAME_ERR_EN
                        if (w_rx_s) begin
                            w_data_d = r_shift;
                            w_done_d = 1'b1;
                        end else begin
                            w_err_d = 1'b1;
                        end
`else
                        w_data_d = r_shift;
                        w_done_d = 1'b1;
`endif
                    end else begin
                        w_tick_d = r_tick + 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign rx_data = r_data;
    assign rx_done = r_done;
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = r_err;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: sample-instant reference model plus directed frames.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned OS      = 16;
    localparam int unsigned DB      = 8;
    localparam int unsigned BIT_CLK = OS * 4;
`ifdef UART_RX_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          br_tick = 1'b0;
    logic          rx      = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_done;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .br_tick   (br_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        int unsigned div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            br_tick = (div == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the line as seen through two clocks of synchronizer latency, a start
    // detected on a low level, then decisions at tick 8 (start) and every 16 ticks after.
    logic          exp_done = 1'b0;
    logic          exp_err  = 1'b0;
    logic [DB-1:0] exp_data = '0;

    initial begin
        logic [1:0]    hist;
        logic          rxs;
        bit            busy;
        int            cnt;
        int            idx;
        logic [DB-1:0] sh;
        hist = 2'b11;
        busy = 1'b0;
        cnt  = 0;
        sh   = '0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                hist     = 2'b11;
                busy     = 1'b0;
                cnt      = 0;
                sh       = '0;
                exp_done = 1'b0;
                exp_err  = 1'b0;
                exp_data = '0;
            end else begin
                rxs      = hist[1];
                exp_done = 1'b0;
                exp_err  = 1'b0;
                if (!busy) begin
                    if (!rxs) begin
                        busy = 1'b1;
                        cnt  = 0;
                    end
                end else if (br_tick) begin
                    cnt++;
                    if (cnt == OS / 2) begin
                        if (rxs) busy = 1'b0;
                    end else if (cnt > OS / 2 && (cnt - OS / 2) % OS == 0) begin
                        idx = (cnt - OS / 2) / OS - 1;
                        if (idx < DB) begin
                            sh[idx] = rxs;
                        end else begin
                            busy = 1'b0;
                            if (rxs || !ERR_EN) begin
                                exp_done = 1'b1;
                                exp_data = sh;
                            end else begin
                                exp_err = 1'b1;
                            end
                        end
                    end
                end
                hist = {hist[0], rx};
            end
        end
    end

    logic [7:0] got_q[$];
    logic [7:0] mdl_q[$];
    int         got_err = 0;
    int         mdl_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rx_done", 32'(rx_done), 32'(exp_done));
                chk("frame_err", 32'(frame_err), 32'(exp_err));
                chk("rx_data", 32'(rx_data), 32'(exp_data));
                if (rx_done) got_q.push_back(rx_data);
                if (frame_err) got_err++;
                if (exp_done) mdl_q.push_back(exp_data);
                if (exp_err) mdl_err++;
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop_bit;
        if (stop_bit) begin
            repeat (BIT_CLK) @(negedge clk);
        end else begin
            // Low across the stop sample, then idle so the tail reads as a short glitch.
            repeat (40) @(negedge clk);
            rx = 1'b1;
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    task automatic expect_frames(input string nm, input int n, input logic [7:0] e0,
                                 input logic [7:0] e1, input logic [7:0] e2, input int n_err);
        logic [7:0] e[3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        chk({nm, "_dut_cnt"}, 32'(got_q.size()), 32'(n));
        chk({nm, "_mdl_cnt"}, 32'(mdl_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (got_q.size() > i) chk({nm, "_dut_val"}, 32'(got_q[i]), 32'(e[i]));
            if (mdl_q.size() > i) chk({nm, "_mdl_val"}, 32'(mdl_q[i]), 32'(e[i]));
        end
        chk({nm, "_dut_err"}, 32'(got_err), 32'(n_err));
        chk({nm, "_mdl_err"}, 32'(mdl_err), 32'(n_err));
        got_q.delete();
        mdl_q.delete();
        got_err = 0;
        mdl_err = 0;
    endtask

    initial begin
        logic [7:0] abort_byte;
        int         r;
        abort_byte = 8'hC3;
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rx_done", 32'(rx_done), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_sync", 32'(dut.w_rx_s), 32'h1);
        #2 reset = 1'b1;
        idle(20);

        send_frame(8'hA5, 1'b1);
        idle(10);
        expect_frames("a5", 1, 8'hA5, 8'h00, 8'h00, 0);

        rx = 1'b0;
        repeat (12) @(negedge clk);
        idle(100);
        expect_frames("false_start", 0, 8'h00, 8'h00, 8'h00, 0);
        chk("false_start_idle", 32'(dut.r_state), 32'(StIdle));

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(10);
        expect_frames("b2b", 3, 8'h00, 8'hFF, 8'h3C, 0);

        send_frame(8'h5A, 1'b0);
        idle(10);
        if (ERR_EN) begin
            expect_frames("bad_stop", 0, 8'h00, 8'h00, 8'h00, 1);
            chk("bad_stop_hold", 32'(rx_data), 32'h3C);
        end else begin
            expect_frames("bad_stop", 1, 8'h5A, 8'h00, 8'h00, 0);
        end

        // Abort 0xC3 halfway through bit 4.
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = abort_byte[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        #2 reset = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_rx_data", 32'(rx_data), 32'h0);
        chk("midrst_rx_done", 32'(rx_done), 32'h0);
        #2 reset = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1);
        idle(10);
        expect_frames("after_rst", 1, 8'h81, 8'h00, 8'h00, 0);

        for (int k = 0; k < 25; k++) begin
            idle($urandom_range(0, 80));
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 24)) @(negedge clk);
                idle(100);
            end else begin
                send_frame(8'($urandom), (r != 1));
            end
        end
        idle(20);
        chk("rand_frame_cnt", 32'(got_q.size()), 32'(mdl_q.size()));
        chk("rand_err_cnt", 32'(got_err), 32'(mdl_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
